mdu_f: RTL and testbench
========================

MDU_F -- requirements
Module: mdu_f

Interface
REQ-001: Parameter WIDTH, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002: Parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  request; sampled only in IDLE.
REQ-006: op  input  mdu_op_t (3)  MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007: a  input  WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO source).
REQ-008: b  input  WIDTH  rt operand (multiplier/divisor).
REQ-009: flush  input  1  abort in-flight operation (branch/exception squash).
REQ-010: busy  output  1  operation in progress; hazard unit stalls F/D on MFHI/MFLO or new MDU op while high.
REQ-011: done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-012: hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013: States SHALL be IDLE, CALC, SIGN, DONE.
REQ-014: IDLE + start + MULT/MULTU/DIV/DIVU SHALL latch operand magnitudes (signed ops: two's-complement absolute value; unsigned: raw), record result signs, clear counter, go to CALC.
REQ-015: IDLE + start + MTHI (MTLO) SHALL write a into hi (lo) at that edge, stay IDLE, keep busy low, and pulse done next cycle.
REQ-016: CALC SHALL run exactly WIDTH iterations, one per cycle: shift-add multiply (2*WIDTH product) or restoring divide (one quotient bit per cycle).
REQ-017: After iteration WIDTH, CALC SHALL go to SIGN; SIGN SHALL negate product (if operand signs differ), quotient (if signs differ), remainder (if dividend negative), then go to DONE.
REQ-018: DONE SHALL load hi/lo (MULT: hi=upper, lo=lower product; DIV: lo=quotient, hi=remainder), assert done for one cycle, go to IDLE.
REQ-019: Latency: start accepted at edge N; busy high cycles N+1..N+WIDTH+2; hi/lo and done valid in cycle N+WIDTH+3; new start accepted same cycle.
REQ-020: busy SHALL be high in CALC, SIGN and DONE only.
REQ-021: start while busy SHALL be ignored; no queuing.
REQ-022: Divide by zero (b==0) SHALL yield lo = all ones, hi = a unmodified, same latency, no error flag.
REQ-023: Signed DIV of most-negative by -1 SHALL yield lo = most-negative, hi = 0 (wrap, no trap).
REQ-024: flush in CALC or SIGN SHALL return to IDLE next edge, leave hi/lo unchanged, suppress done.
REQ-025: flush in DONE SHALL NOT cancel the write; result commits.
REQ-026: flush and start together in IDLE SHALL discard start.
REQ-027: All arithmetic SHALL be modulo 2*WIDTH internally; no truncation before SIGN.

Reset
REQ-028: reset low SHALL immediately force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, internal operand/accumulator registers 0.
REQ-029: Reset mid-operation SHALL abandon the operation; first start after reset release SHALL behave per REQ-014.

Structure
REQ-030: mdu_op_t and the state enum SHALL reside in shared package mips_decls_p, alongside opcode_t and funct_t.
REQ-031: Default opcode/funct encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO SHALL be added to mips_decls_p.
REQ-032: One sub-module, mdu_negate (parametrised conditional two's-complement), SHALL be instantiated for operand and result sign handling.
REQ-033: MFHI/MFLO SHALL read hi/lo combinationally in the datapath; the unit has no read port.

Verification (WIDTH=32)
REQ-034: MULT a=7, b=FFFFFFFD -> after 35 cycles hi=FFFFFFFF, lo=FFFFFFEB, done one pulse, busy high exactly 34 cycles.
REQ-035: MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036: DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678.
REQ-037: MTLO a=A5A5A5A5 then DIV started, flush at iteration 10 -> lo stays A5A5A5A5, no done, busy low next cycle.
REQ-038: Second start issued during busy -> ignored; only first result committed; reset pulled low mid-CALC -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mips_decls_p.sv
// Shared MIPS decode declarations: opcode/funct encodings plus the
// multiply/divide unit operation and state types.
package mips_decls_p;

  // Primary opcode field (instr[31:26])
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  // SPECIAL funct field (instr[5:0]); HI/LO group only
  typedef enum logic [5:0] {
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B
  } funct_t;

  // Operations accepted by the multiply/divide unit
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_SIGN = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  function automatic logic mdu_op_signed(mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic mdu_op_is_div(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_f_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_f_if #(
  parameter int WIDTH = 32
);
  import mips_decls_p::*;

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement: passes the value through or negates it.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/mdu_f.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are processed unsigned (shift-add / restoring divide, one bit
// per cycle) and signs are applied in a single fix-up cycle afterwards.
module mdu_f
  import mips_decls_p::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic  clk,
  input  logic  reset,
  mdu_f_if.slave bus
);

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi part, lo part} working register
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d; // negate product / quotient
  logic               neg_hi_q, neg_hi_d; // negate remainder
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes for the incoming request
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sign_a = mdu_op_signed(bus.op) & bus.a[WIDTH-1];
  assign sign_b = mdu_op_signed(bus.op) & bus.b[WIDTH-1];

  mdu_negate #(.W(WIDTH)) u_neg_a (.neg_i(sign_a), .val_i(bus.a), .val_o(a_mag));
  mdu_negate #(.W(WIDTH)) u_neg_b (.neg_i(sign_b), .val_i(bus.b), .val_o(b_mag));

  // Result sign fix-up: full product, or independent quotient/remainder
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  mdu_negate #(.W(2*WIDTH)) u_neg_prod (.neg_i(neg_lo_q), .val_i(acc_q), .val_o(prod_s));
  mdu_negate #(.W(WIDTH)) u_neg_quo (.neg_i(neg_lo_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_s));
  mdu_negate #(.W(WIDTH)) u_neg_rem (.neg_i(neg_hi_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .val_o(rem_s));

  // One multiply step: conditionally add multiplicand to upper half, shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step on the shifted partial remainder
  logic [WIDTH:0]     div_rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_step;
  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge     = div_rem_sh >= {1'b0, opb_q};
  assign div_sub    = div_rem_sh[WIDTH-1:0] - opb_q;
  assign div_step   = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[2*WIDTH-2:0], 1'b0};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            MDU_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_d = mdu_op_is_div(bus.op);
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opb_d    = b_mag;
              // Divide by zero keeps the all-ones quotient unsigned
              neg_lo_d = (sign_a ^ sign_b) && !(mdu_op_is_div(bus.op) && (b_mag == '0));
              neg_hi_d = mdu_op_is_div(bus.op) && sign_a;
              cnt_d    = '0;
              state_d  = MDU_CALC;
            end
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        if (bus.flush) begin
          state_d = MDU_IDLE;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDU_SIGN;
        end
      end
      MDU_SIGN: begin
        if (bus.flush) begin
          state_d = MDU_IDLE;
        end else begin
          acc_d   = is_div_q ? {rem_s, quo_s} : prod_s;
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        // A flush arriving here is too late to cancel the commit
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign bus.busy = (state_q != MDU_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_f.sv
// Directed self-checking bench for mdu_f at WIDTH=32.
module tb_mdu_f;
  import mips_decls_p::*;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  mdu_f_if #(.WIDTH(32)) bus ();

  mdu_f #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op and watch busy/done until the result appears
  task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int done_at);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    busy_n    = 0;
    done_at   = 0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = i;
        break;
      end
      step();
    end
  endtask

  task automatic do_arith(input string tag, input mdu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    int busy_n, done_at;
    run_op(op, a, b, busy_n, done_at);
    $display("%s op=%s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done_cycle=%0d",
             tag, op.name(), a, b, bus.hi, bus.lo, busy_n, done_at);
    check({tag, "_done_cycle"}, 64'(done_at), 64'd35);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd34);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    check({tag, "_done_one_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int saw_done;
    int i;
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    repeat (2) step();

    // Reset state
    $display("reset held low");
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1;
    step();

    // Arithmetic vectors
    do_arith("mult_7_m3", MDU_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_arith("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_arith("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_arith("divu_by0", MDU_DIVU, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
    do_arith("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_arith("div_m5_by0", MDU_DIV, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTHI / MTLO: immediate write, no busy, done next cycle
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.a = 32'h1111_2222;
    step();
    bus.start = 1'b0;
    $display("mthi a=11112222 -> hi=%h done=%b busy=%b", bus.hi, bus.done, bus.busy);
    check("mthi_hi", 64'(bus.hi), 64'h1111_2222);
    check("mthi_done", 64'(bus.done), 64'd1);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1; bus.op = MDU_MTLO; bus.a = 32'hA5A5_A5A5;
    step();
    bus.start = 1'b0;
    $display("mtlo a=a5a5a5a5 -> lo=%h done=%b busy=%b", bus.lo, bus.done, bus.busy);
    check("mtlo_lo", 64'(bus.lo), 64'hA5A5_A5A5);
    check("mtlo_done", 64'(bus.done), 64'd1);
    step();
    check("mtlo_done_one_pulse", 64'(bus.done), 64'd0);

    // DIV flushed at iteration 10
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd100; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    $display("div flushed in calc -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    check("flush_calc_busy", 64'(bus.busy), 64'd0);
    check("flush_calc_lo", 64'(bus.lo), 64'hA5A5_A5A5);
    check("flush_calc_hi", 64'(bus.hi), 64'h1111_2222);
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) saw_done = 1;
      step();
    end
    check("flush_calc_no_done", 64'(saw_done), 64'd0);

    // MULTU flushed in SIGN (cycle 33 after acceptance)
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd2; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (32) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    $display("multu flushed in sign -> busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    check("flush_sign_busy", 64'(bus.busy), 64'd0);
    check("flush_sign_done", 64'(bus.done), 64'd0);
    check("flush_sign_lo", 64'(bus.lo), 64'hA5A5_A5A5);

    // DIVU with flush in DONE (cycle 34): result still commits
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (33) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    $display("divu flushed in done -> done=%b hi=%h lo=%h", bus.done, bus.hi, bus.lo);
    check("flush_done_done", 64'(bus.done), 64'd1);
    check("flush_done_lo", 64'(bus.lo), 64'd14);
    check("flush_done_hi", 64'(bus.hi), 64'd2);

    // Flush together with start in IDLE discards the request
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_MTHI; bus.a = 32'hDEAD_BEEF;
    step();
    bus.op = MDU_MULT; bus.a = 32'd9; bus.b = 32'd9;
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    $display("start+flush in idle -> hi=%h busy=%b done=%b", bus.hi, bus.busy, bus.done);
    check("idle_flush_hi", 64'(bus.hi), 64'd2);
    check("idle_flush_busy", 64'(bus.busy), 64'd0);
    check("idle_flush_done", 64'(bus.done), 64'd0);

    // Second start while busy is ignored
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd3; bus.b = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd100; bus.b = 32'd100;
    step();
    bus.start = 1'b0;
    i = 6;
    while (!bus.done && i < 60) begin
      step();
      i++;
    end
    $display("multu 3*5 with start during busy -> hi=%h lo=%h done_cycle=%0d", bus.hi, bus.lo, i);
    check("busy_start_done_cycle", 64'(i), 64'd35);
    check("busy_start_lo", 64'(bus.lo), 64'd15);
    check("busy_start_hi", 64'(bus.hi), 64'd0);
    step();
    check("busy_start_no_queue", 64'(bus.busy), 64'd0);

    // Reset asserted mid-CALC clears everything immediately
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    #1;
    $display("reset mid-calc -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    step();
    reset = 1'b1;
    step();
    do_arith("post_rst_div", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
